// File: rtl/trade_pkg.sv
// Shared types and constants for the result-BRAM read path.
package trade_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        PRESENT,
        FINISH
    } rr_state_e;

    localparam int unsigned WORDS_PER_REC  = 4;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned REC_BYTES      = WORDS_PER_REC * BYTES_PER_WORD;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned LANE_W         = 2;
    localparam int unsigned REC_W          = WORDS_PER_REC * WORD_W;

    // Byte address of one word within a record; wraps modulo 2^32.
    function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [LANE_W-1:0] lane);
        return base + ADDR_W'(lane) * ADDR_W'(BYTES_PER_WORD);
    endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Delay line carrying {valid, lane} alongside the BRAM read so capture lines up with doutB.
module rd_lat_pipe
    import trade_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [LANE_W-1:0] lane_i,
    output logic              valid_o,
    output logic [LANE_W-1:0] lane_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [LANE_W-1:0] lane_q [RD_LAT];

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) lane_q[i] <= '0;
        end else begin
            vld_q[0]  <= valid_i;
            lane_q[0] <= lane_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                lane_q[i] <= lane_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[RD_LAT-1];
    assign lane_o  = lane_q[RD_LAT-1];

endmodule

// File: rtl/result_reader.sv
// Reads numRecs 128-bit records from the result BRAM (port B) and streams them out valid/ready.
// Optional RESULT_CHECKSUM_EN adds a running 32-bit sum of all transferred words.
module result_reader
    import trade_pkg::*;
#(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fdone,
    input  logic [CNT_W-1:0]  numRecs,
    input  logic [ADDR_W-1:0] baseAddr,
    output logic              enB,
    output logic [3:0]        web,
    output logic [ADDR_W-1:0] addrB,
    input  logic [WORD_W-1:0] doutB,
    output logic [REC_W-1:0]  recData,
    output logic              recValid,
    input  logic              recReady,
    output logic              busy,
    output logic              done
`ifdef RESULT_CHECKSUM_EN
    ,
    output logic [WORD_W-1:0] checksum
`endif
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORDS_PER_REC - 1);

    rr_state_e         state_q, state_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rec_q, rec_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic              enb_q, enb_d;
    logic [ADDR_W-1:0] addrb_q, addrb_d;
    logic [REC_W-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              pipe_valid;
    logic [LANE_W-1:0] pipe_lane;
    logic              xfer;

    rd_lat_pipe #(.RD_LAT(RD_LAT)) u_pipe (
        .clock   (clock),
        .reset   (reset),
        .valid_i (enb_q),
        .lane_i  (lane_q),
        .valid_o (pipe_valid),
        .lane_o  (pipe_lane)
    );

    assign xfer = valid_q & recReady;

    // Next-state, read issue and lane capture.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        addr_d  = addr_q;
        rec_d   = rec_q;
        num_d   = num_q;
        data_d  = data_q;
        valid_d = valid_q;

        if (pipe_valid) data_d[{pipe_lane, 5'd0} +: WORD_W] = doutB;

        case (state_q)
            IDLE: begin
                if (fdone) begin
                    num_d   = numRecs;
                    addr_d  = baseAddr;
                    rec_d   = '0;
                    lane_d  = '0;
                    state_d = (numRecs != '0) ? ISSUE : FINISH;
                end
            end
            ISSUE: begin
                if (lane_q == LAST_LANE) state_d = DRAIN;
                else                     lane_d  = LANE_W'(lane_q + 2'd1);
            end
            DRAIN: begin
                if (pipe_valid && (pipe_lane == LAST_LANE)) begin
                    state_d = PRESENT;
                    valid_d = 1'b1;
                end
            end
            PRESENT: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    rec_d   = CNT_W'(rec_q + 1'b1);
                    addr_d  = addr_q + ADDR_W'(REC_BYTES);
                    lane_d  = '0;
                    state_d = (CNT_W'(rec_q + 1'b1) == num_q) ? FINISH : ISSUE;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        enb_d   = (state_d == ISSUE);
        addrb_d = enb_d ? lane_addr(addr_d, lane_d) : addrb_q;
        busy_d  = (state_d != IDLE);
        done_d  = (state_q == FINISH);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            lane_q  <= '0;
            addr_q  <= '0;
            rec_q   <= '0;
            num_q   <= '0;
            enb_q   <= 1'b0;
            addrb_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            addr_q  <= addr_d;
            rec_q   <= rec_d;
            num_q   <= num_d;
            enb_q   <= enb_d;
            addrb_q <= addrb_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign enB      = enb_q;
    assign web      = 4'b0000;
    assign addrB    = addrb_q;
    assign recData  = data_q;
    assign recValid = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef RESULT_CHECKSUM_EN
    logic [WORD_W-1:0] csum_q, csum_d;

    // Cleared when a run is accepted; summed over every transferred record.
    always_comb begin
        csum_d = csum_q;
        if ((state_q == IDLE) && fdone) begin
            csum_d = '0;
        end else if (xfer) begin
            csum_d = csum_q + data_q[31:0] + data_q[63:32] + data_q[95:64] + data_q[127:96];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) csum_q <= '0;
        else       csum_q <= csum_d;
    end

    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_result_reader.sv
// Scoreboard bench for result_reader: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=2.
module tb_result_reader;

    logic         clk;
    logic         rst      [2];
    logic         fdone    [2];
    logic [7:0]   numRecs  [2];
    logic [31:0]  baseAddr [2];
    logic         enB      [2];
    logic [3:0]   web      [2];
    logic [31:0]  addrB    [2];
    logic [31:0]  doutB    [2];
    logic [127:0] recData  [2];
    logic         recValid [2];
    logic         recReady [2];
    logic         busy     [2];
    logic         done     [2];
`ifdef RESULT_CHECKSUM_EN
    logic [31:0]  checksum [2];
`endif

    for (genvar g = 0; g < 2; g++) begin : g_dut
        result_reader #(.RD_LAT(g + 1), .CNT_W(8)) u_dut (
            .clock    (clk),
            .reset    (rst[g]),
            .fdone    (fdone[g]),
            .numRecs  (numRecs[g]),
            .baseAddr (baseAddr[g]),
            .enB      (enB[g]),
            .web      (web[g]),
            .addrB    (addrB[g]),
            .doutB    (doutB[g]),
            .recData  (recData[g]),
            .recValid (recValid[g]),
            .recReady (recReady[g]),
            .busy     (busy[g]),
            .done     (done[g])
`ifdef RESULT_CHECKSUM_EN
            ,
            .checksum (checksum[g])
`endif
        );
    end

    // BRAM model: the word at byte address a holds a; garbage when not enabled.
    logic [31:0] bram_d1 [2];
    logic [31:0] bram_d2 [2];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bram_d1[d] <= enB[d] ? addrB[d] : 32'hDEAD_BEEF;
            bram_d2[d] <= bram_d1[d];
        end
    end
    assign doutB[0] = bram_d1[0];
    assign doutB[1] = bram_d2[1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           n_vec = 0;
    int           n_err = 0;
    logic [31:0]  exp_addr_q [$];
    logic [127:0] exp_rec_q  [$];
    logic [31:0]  exp_done_q [$];
    int           rise_q     [$];
    int           fdone_cyc;
    int           last_done_cyc;
    logic [127:0] last_rec   [2];
    logic         valid_prev [2];

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endfunction

    function automatic void expect_run(input int n, input logic [31:0] base);
        logic [31:0]  a;
        logic [31:0]  sum;
        logic [127:0] r;
        a   = base;
        sum = '0;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                exp_addr_q.push_back(a + 32'(4 * k));
                r[32*k +: 32] = a + 32'(4 * k);
                sum = sum + a + 32'(4 * k);
            end
            exp_rec_q.push_back(r);
            a = a + 32'd16;
        end
        exp_done_q.push_back(sum);
    endfunction

    task automatic monitor();
        logic [31:0] a;
        forever begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (enB[d]) begin
                    if (exp_addr_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL enB_unexpected: dut%0d read 0x%0h, required no read", d, addrB[d]);
                    end else begin
                        a = exp_addr_q.pop_front();
                        chk("addrB", 128'(addrB[d]), 128'(a));
                    end
                end
                if (recValid[d] && !valid_prev[d]) rise_q.push_back(cyc);
                valid_prev[d] = recValid[d];
                if (recValid[d] && recReady[d]) begin
                    last_rec[d] = recData[d];
                    if (exp_rec_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rec_unexpected: dut%0d got 0x%0h, required none", d, recData[d]);
                    end else begin
                        chk("recData", recData[d], exp_rec_q.pop_front());
                    end
                end
                if (done[d]) begin
                    last_done_cyc = cyc;
                    if (exp_done_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL done_unexpected: dut%0d pulsed done at cycle %0d, required none", d, cyc);
                    end else begin
                        a = exp_done_q.pop_front();
                        chk("busy_at_done", 128'(busy[d]), 128'd0);
`ifdef RESULT_CHECKSUM_EN
                        chk("checksum", 128'(checksum[d]), 128'(a));
`endif
                    end
                end
            end
        end
    endtask

    task automatic start(input int d, input logic [7:0] n, input logic [31:0] base);
        @(negedge clk);
        expect_run(int'(n), base);
        rise_q.delete();
        numRecs[d]  = n;
        baseAddr[d] = base;
        fdone[d]    = 1'b1;
        fdone_cyc   = cyc;
        @(negedge clk);
        fdone[d]    = 1'b0;
        numRecs[d]  = 8'hFF;
        baseAddr[d] = 32'hDEAD_0000;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_addr_q.size() == 0 && exp_rec_q.size() == 0 && exp_done_q.size() == 0) break;
        end
        chk("drain_complete", 128'(exp_addr_q.size() + exp_rec_q.size() + exp_done_q.size()), 128'd0);
        exp_addr_q.delete();
        exp_rec_q.delete();
        exp_done_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input int d, input string tag);
        chk({tag, "_enB"},     128'(enB[d]),      128'd0);
        chk({tag, "_addrB"},   128'(addrB[d]),    128'd0);
        chk({tag, "_recData"}, recData[d],        128'd0);
        chk({tag, "_recValid"},128'(recValid[d]), 128'd0);
        chk({tag, "_busy"},    128'(busy[d]),     128'd0);
        chk({tag, "_done"},    128'(done[d]),     128'd0);
        chk({tag, "_web"},     128'(web[d]),      128'd0);
`ifdef RESULT_CHECKSUM_EN
        chk({tag, "_checksum"},128'(checksum[d]), 128'd0);
`endif
    endtask

    task automatic run_tests();
        bit seen;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; fdone[d] = 1'b0; numRecs[d] = '0; baseAddr[d] = '0;
            recReady[d] = 1'b1; valid_prev[d] = 1'b0; last_rec[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) chk_idle_outputs(d, "reset");
        for (int d = 0; d < 2; d++) rst[d] = 1'b0;

        // Single record, RD_LAT=1.
        start(0, 8'd1, 32'h100);
        wait_drain(100);
        chk("t1_rise_count", 128'(rise_q.size()), 128'd1);
        if (rise_q.size() >= 1) chk("t1_latency", 128'(rise_q[0] - fdone_cyc), 128'd6);
        chk("t1_record", last_rec[0], 128'h0000010C_00000108_00000104_00000100);
        chk("t1_done_cycle", 128'(last_done_cyc - fdone_cyc), 128'd8);

        // Three records back to back.
        start(0, 8'd3, 32'h200);
        wait_drain(200);
        chk("t2_rise_count", 128'(rise_q.size()), 128'd3);
        if (rise_q.size() >= 3) begin
            chk("t2_spacing_01", 128'(rise_q[1] - rise_q[0]), 128'd6);
            chk("t2_spacing_12", 128'(rise_q[2] - rise_q[1]), 128'd6);
        end
        chk("t2_done_cycle", 128'(last_done_cyc - fdone_cyc), 128'd20);

        // Downstream stall for 10+ cycles.
        recReady[0] = 1'b0;
        start(0, 8'd1, 32'h300);
        for (int i = 0; i < 40; i++) begin
            if (recValid[0]) break;
            @(negedge clk);
        end
        chk("t3_valid_seen", 128'(recValid[0]), 128'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_stall_valid", 128'(recValid[0]), 128'd1);
            chk("t3_stall_data",  recData[0], 128'h0000030C_00000308_00000304_00000300);
            chk("t3_stall_enB",   128'(enB[0]), 128'd0);
        end
        recReady[0] = 1'b1;
        wait_drain(50);

        // Zero-record run.
        start(0, 8'd0, 32'h700);
        wait_drain(50);
        chk("t4_done_cycle", 128'(last_done_cyc - fdone_cyc), 128'd2);
        chk("t4_no_valid",   128'(rise_q.size()), 128'd0);

        // RD_LAT=2 with address wrap.
        start(1, 8'd2, 32'hFFFF_FFF8);
        wait_drain(200);
        chk("t5_rise_count", 128'(rise_q.size()), 128'd2);
        if (rise_q.size() >= 2) begin
            chk("t5_latency", 128'(rise_q[0] - fdone_cyc), 128'd7);
            chk("t5_spacing", 128'(rise_q[1] - rise_q[0]), 128'd7);
        end
        chk("t5_record", last_rec[1], 128'h00000014_00000010_0000000C_00000008);

        // Extra fdone while busy must not start a second run.
        start(0, 8'd2, 32'h400);
        repeat (2) @(negedge clk);
        numRecs[0] = 8'd5; baseAddr[0] = 32'h900; fdone[0] = 1'b1;
        @(negedge clk);
        fdone[0] = 1'b0;
        wait_drain(200);
        repeat (30) @(negedge clk);
        chk("t6_idle_busy", 128'(busy[0]), 128'd0);

        // Reset during DRAIN discards the partial record.
        @(negedge clk);
        for (int k = 0; k < 4; k++) exp_addr_q.push_back(32'h500 + 32'(4 * k));
        numRecs[1] = 8'd1; baseAddr[1] = 32'h500; fdone[1] = 1'b1;
        @(negedge clk);
        fdone[1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (enB[1]) seen = 1'b1;
            else if (seen) break;
        end
        chk("t7_busy_in_drain", 128'(busy[1]), 128'd1);
        rst[1] = 1'b1;
        @(negedge clk);
        chk_idle_outputs(1, "t7_midreset");
        rst[1] = 1'b0;
        repeat (20) @(negedge clk);
        chk("t7_reads_issued", 128'(exp_addr_q.size()), 128'd0);
        exp_addr_q.delete();

        // Fresh run after the mid-run reset.
        start(1, 8'd1, 32'h600);
        wait_drain(100);
        chk("t8_record", last_rec[1], 128'h0000060C_00000608_00000604_00000600);
    endtask

    initial begin
        fork
            monitor();
            run_tests();
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
